// File: rtl/clint_rtc_pkg.sv
// rtl/clint_rtc_pkg.sv - shared types and constants for the RTC generator
package clint_rtc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } rtc_state_e;

  localparam int RtcAccWidthDefault = 32;

endpackage

// File: rtl/clint_rtc_incr_slot.sv
// rtl/clint_rtc_incr_slot.sv - single-entry holding register for a pending increment
module clint_rtc_incr_slot
  import clint_rtc_pkg::*;
#(
  parameter int Width = RtcAccWidthDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             apply_i,
  output logic [Width-1:0] pend_o,
  output logic             pend_valid_o
);

  logic [Width-1:0] pend_q, pend_d;
  logic             valid_q, valid_d;

  // Apply empties the slot; a load only arrives while it is empty.
  always_comb begin
    pend_d  = pend_q;
    valid_d = valid_q;
    if (apply_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      pend_d  = data_i;
      valid_d = 1'b1;
    end
  end

  // Slot storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
    end
  end

  assign pend_o       = pend_q;
  assign pend_valid_o = valid_q;

endmodule

// File: rtl/clint_rtc_gen.sv
// rtl/clint_rtc_gen.sv - fractional phase-accumulator RTC square-wave generator
module clint_rtc_gen
  import clint_rtc_pkg::*;
#(
  parameter int          AccWidth    = RtcAccWidthDefault,
  parameter logic [31:0] DefaultIncr = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                halt_i,
  input  logic [AccWidth-1:0] incr_i,
  input  logic                incr_valid_i,
  output logic                incr_ready_o,
  output logic                rtc_o,
  output logic                tick_o,
  output logic                busy_o
);

  localparam logic [AccWidth-1:0] ResetIncr = AccWidth'(DefaultIncr);

  rtc_state_e          state_q, state_d;
  logic [AccWidth-1:0] acc_q, acc_d;
  logic [AccWidth-1:0] active_q, active_d;
  logic                tick_q, tick_d;

  logic [AccWidth:0]   sum;
  logic [AccWidth-1:0] pend;
  logic                pend_valid;
  logic                accept;
  logic                direct;
  logic                slot_load;
  logic                slot_apply;

  assign sum    = {1'b0, acc_q} + {1'b0, active_q};
  assign accept = incr_valid_i & ~pend_valid;
  // While disabled or still idle there is no running waveform to protect,
  // so a new increment can take effect straight away.
  assign direct = ~en_i | (state_q == IDLE);

  clint_rtc_incr_slot #(
    .Width(AccWidth)
  ) u_slot (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (slot_load),
    .data_i      (incr_i),
    .apply_i     (slot_apply),
    .pend_o      (pend),
    .pend_valid_o(pend_valid)
  );

  // Next-state: accumulate, hand off pending increments only at a wrap, and
  // collapse to idle whenever the generator is disabled.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    active_d   = active_q;
    tick_d     = 1'b0;
    slot_load  = 1'b0;
    slot_apply = 1'b0;

    if (accept && direct) begin
      active_d = incr_i;
    end else if (accept) begin
      slot_load = 1'b1;
    end

    if (!en_i) begin
      acc_d   = '0;
      state_d = IDLE;
      if (pend_valid) begin
        active_d   = pend;
        slot_apply = 1'b1;
      end
    end else if (!halt_i) begin
      acc_d  = sum[AccWidth-1:0];
      tick_d = ~acc_q[AccWidth-1] & sum[AccWidth-1];
      unique case (state_q)
        IDLE: state_d = RUN;
        RUN:  if (slot_load) state_d = PEND;
        PEND: begin
          // A zero increment never wraps, so it would otherwise block forever.
          if (sum[AccWidth] || (active_q == '0)) begin
            active_d   = pend;
            slot_apply = 1'b1;
            state_d    = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      // Halted: the accumulator is frozen, but an accepted value must not be lost.
      if ((state_q == RUN) && slot_load) state_d = PEND;
    end
  end

  // State, accumulator, active increment and tick registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      active_q <= ResetIncr;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      active_q <= active_d;
      tick_q   <= tick_d;
    end
  end

  assign rtc_o        = acc_q[AccWidth-1];
  assign tick_o       = tick_q;
  assign incr_ready_o = ~pend_valid;
  assign busy_o       = pend_valid;

endmodule
